// File: rtl/sync_fifo.sv
// Single-clock FIFO of 2^DEPTH_LOG2 words with registered read port and status flags.
// Define FIFO_ERR_FLAGS_EN to enable sticky overflow/underflow detection.
module sync_fifo #(
  parameter int unsigned N          = 8,
  parameter int unsigned DEPTH_LOG2 = 3,
  parameter int unsigned AF_LEVEL   = 6
) (
  input  logic                  fifo_clk,
  input  logic                  fifo_rst_n,
  input  logic                  fifo_wr_en,
  input  logic [N-1:0]          fifo_wr_data,
  input  logic                  fifo_rd_en,
  output logic [N-1:0]          fifo_rd_data,
  output logic                  fifo_rd_valid,
  output logic                  fifo_full,
  output logic                  fifo_empty,
  output logic                  fifo_almost_full,
  output logic [DEPTH_LOG2:0]   fifo_count,
  input  logic                  fifo_err_clr,
  output logic                  fifo_overflow,
  output logic                  fifo_underflow
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DepthCnt = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] AfCnt    = (DEPTH_LOG2 + 1)'(AF_LEVEL);

  logic [N-1:0]          mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic [N-1:0]          rd_data_q;
  logic                  rd_valid_q;
  logic                  wr_ok, rd_ok;

  // A read never sees a word written on the same edge, so empty blocks reads outright.
  assign rd_ok = fifo_rd_en && (count_q != '0);
  assign wr_ok = fifo_wr_en && ((count_q != DepthCnt) || rd_ok);

  always_comb begin
    count_d = count_q;
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge fifo_clk or negedge fifo_rst_n) begin
    if (!fifo_rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      rd_valid_q <= rd_ok;
      if (wr_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_ok) begin
        rd_ptr_q  <= rd_ptr_q + 1'b1;
        rd_data_q <= mem_q[rd_ptr_q];
      end
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge fifo_clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= fifo_wr_data;
  end

  assign fifo_rd_data     = rd_data_q;
  assign fifo_rd_valid    = rd_valid_q;
  assign fifo_count       = count_q;
  assign fifo_full        = (count_q == DepthCnt);
  assign fifo_empty       = (count_q == '0);
  assign fifo_almost_full = (count_q >= AfCnt);

`ifdef FIFO_ERR_FLAGS_EN
  logic overflow_q, underflow_q;

  // Set takes priority over clear on the same edge.
  always_ff @(posedge fifo_clk or negedge fifo_rst_n) begin
    if (!fifo_rst_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (fifo_wr_en && !wr_ok)   overflow_q <= 1'b1;
      else if (fifo_err_clr)      overflow_q <= 1'b0;
      if (fifo_rd_en && !rd_ok)   underflow_q <= 1'b1;
      else if (fifo_err_clr)      underflow_q <= 1'b0;
    end
  end

  assign fifo_overflow  = overflow_q;
  assign fifo_underflow = underflow_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = fifo_err_clr;
  assign fifo_overflow  = 1'b0;
  assign fifo_underflow = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo: queue-based reference model plus directed literal checks.
module tb_sync_fifo;

`ifdef FIFO_ERR_FLAGS_EN
  localparam bit ErrEn = 1'b1;
`else
  localparam bit ErrEn = 1'b0;
`endif
  localparam int Depth = 8;
  localparam int AfLvl = 6;

  logic       fifo_clk;
  logic       fifo_rst_n;
  logic       fifo_wr_en;
  logic [7:0] fifo_wr_data;
  logic       fifo_rd_en;
  logic [7:0] fifo_rd_data;
  logic       fifo_rd_valid;
  logic       fifo_full;
  logic       fifo_empty;
  logic       fifo_almost_full;
  logic [3:0] fifo_count;
  logic       fifo_err_clr;
  logic       fifo_overflow;
  logic       fifo_underflow;

  sync_fifo #(
    .N          (8),
    .DEPTH_LOG2 (3),
    .AF_LEVEL   (6)
  ) dut (
    .fifo_clk         (fifo_clk),
    .fifo_rst_n       (fifo_rst_n),
    .fifo_wr_en       (fifo_wr_en),
    .fifo_wr_data     (fifo_wr_data),
    .fifo_rd_en       (fifo_rd_en),
    .fifo_rd_data     (fifo_rd_data),
    .fifo_rd_valid    (fifo_rd_valid),
    .fifo_full        (fifo_full),
    .fifo_empty       (fifo_empty),
    .fifo_almost_full (fifo_almost_full),
    .fifo_count       (fifo_count),
    .fifo_err_clr     (fifo_err_clr),
    .fifo_overflow    (fifo_overflow),
    .fifo_underflow   (fifo_underflow)
  );

  initial fifo_clk = 1'b0;
  always #5 fifo_clk = ~fifo_clk;

  int total = 0;
  int bad   = 0;
  bit check_en = 1'b0;

  // Reference model: contents as a queue, plus the registered outputs.
  logic [7:0] m_q[$];
  logic [7:0] m_rd_data;
  bit         m_rd_valid, m_ovf, m_udf;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_rd_data  = '0;
    m_rd_valid = 1'b0;
    m_ovf      = 1'b0;
    m_udf      = 1'b0;
  endtask

  task automatic model_edge(input bit wr, input logic [7:0] d, input bit rd, input bit clr);
    bit rd_ok, wr_ok;
    rd_ok = rd && (m_q.size() > 0);
    wr_ok = wr && ((m_q.size() < Depth) || rd_ok);
    m_rd_valid = rd_ok;
    if (rd_ok) m_rd_data = m_q.pop_front();
    if (wr_ok) m_q.push_back(d);
    if (ErrEn) begin
      if (wr && !wr_ok) m_ovf = 1'b1;
      else if (clr)     m_ovf = 1'b0;
      if (rd && !rd_ok) m_udf = 1'b1;
      else if (clr)     m_udf = 1'b0;
    end
  endtask

  // Drive one cycle; returns 1 time unit after the edge with the model updated.
  task automatic step(input bit wr, input logic [7:0] d, input bit rd, input bit clr);
    fifo_wr_en   = wr;
    fifo_wr_data = d;
    fifo_rd_en   = rd;
    fifo_err_clr = clr;
    @(posedge fifo_clk);
    model_edge(wr, d, rd, clr);
    #1;
  endtask

  task automatic do_reset();
    fifo_rst_n   = 1'b0;
    fifo_wr_en   = 1'b0;
    fifo_rd_en   = 1'b0;
    fifo_err_clr = 1'b0;
    fifo_wr_data = '0;
    model_reset();
    #1;
    chk("async_rst_count", 32'(fifo_count), 32'd0);
    chk("async_rst_valid", 32'(fifo_rd_valid), 32'd0);
    @(posedge fifo_clk);
    @(negedge fifo_clk);
    fifo_rst_n = 1'b1;
    step(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge fifo_clk);
      if (check_en) begin
        chk("count",       32'(fifo_count), 32'(m_q.size()));
        chk("empty",       32'(fifo_empty), 32'(m_q.size() == 0));
        chk("full",        32'(fifo_full), 32'(m_q.size() == Depth));
        chk("almost_full", 32'(fifo_almost_full), 32'(m_q.size() >= AfLvl));
        chk("rd_valid",    32'(fifo_rd_valid), 32'(m_rd_valid));
        chk("rd_data",     32'(fifo_rd_data), 32'(m_rd_data));
        chk("overflow",    32'(fifo_overflow), 32'(m_ovf));
        chk("underflow",   32'(fifo_underflow), 32'(m_udf));
      end
    end
  end

  initial begin
    int p_wr, p_rd;
    fifo_rst_n = 1'b0;
    model_reset();
    check_en = 1'b1;
    do_reset();

    // Reset then idle
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("rst_empty", 32'(fifo_empty), 32'd1);
    chk("rst_full", 32'(fifo_full), 32'd0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_rd_data", 32'(fifo_rd_data), 32'd0);

    // Fill 0x01..0x08
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 8'(i), 1'b0, 1'b0);
      chk("fill_af", 32'(fifo_almost_full), 32'(i >= 6));
    end
    chk("fill_full", 32'(fifo_full), 32'd1);
    chk("fill_count", 32'(fifo_count), 32'd8);
    step(1'b1, 8'hFF, 1'b0, 1'b0);
    chk("ovf_count", 32'(fifo_count), 32'd8);
    chk("ovf_flag", 32'(fifo_overflow), 32'(ErrEn));

    // Drain back-to-back
    for (int i = 1; i <= 8; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("drain_valid", 32'(fifo_rd_valid), 32'd1);
      chk("drain_data", 32'(fifo_rd_data), 32'(i));
    end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("udf_empty", 32'(fifo_empty), 32'd1);
    chk("udf_flag", 32'(fifo_underflow), 32'(ErrEn));
    chk("udf_rd_data", 32'(fifo_rd_data), 32'h08);
    chk("udf_valid", 32'(fifo_rd_valid), 32'd0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("clr_ovf", 32'(fifo_overflow), 32'd0);
    chk("clr_udf", 32'(fifo_underflow), 32'd0);

    // Full with simultaneous read and write
    for (int i = 1; i <= 8; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    step(1'b1, 8'hAA, 1'b1, 1'b0);
    chk("fullrw_data", 32'(fifo_rd_data), 32'h01);
    chk("fullrw_count", 32'(fifo_count), 32'd8);
    chk("fullrw_ovf", 32'(fifo_overflow), 32'd0);
    for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("fullrw_last", 32'(fifo_rd_data), 32'hAA);

    // Empty with simultaneous read and write: no fall-through
    step(1'b1, 8'h55, 1'b1, 1'b0);
    chk("emptyrw_count", 32'(fifo_count), 32'd1);
    chk("emptyrw_valid", 32'(fifo_rd_valid), 32'd0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("emptyrw_data", 32'(fifo_rd_data), 32'h55);
    chk("emptyrw_valid2", 32'(fifo_rd_valid), 32'd1);
    step(1'b0, 8'h00, 1'b0, 1'b1);

    // Randomized phases biased toward filling, draining and balanced traffic
    for (int ph = 0; ph < 24; ph++) begin
      case (ph % 3)
        0:       begin p_wr = 85; p_rd = 20; end
        1:       begin p_wr = 20; p_rd = 85; end
        default: begin p_wr = 60; p_rd = 60; end
      endcase
      for (int c = 0; c < 60; c++) begin
        step($urandom_range(0, 99) < p_wr, 8'($urandom), $urandom_range(0, 99) < p_rd,
             $urandom_range(0, 15) == 0);
      end
    end

    // Reset mid-stream with data in flight
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
    fifo_rd_en = 1'b1;
    @(posedge fifo_clk);
    model_edge(1'b0, 8'h00, 1'b1, 1'b0);
    #3;
    do_reset();
    chk("midrst_count", 32'(fifo_count), 32'd0);
    chk("midrst_empty", 32'(fifo_empty), 32'd1);
    chk("midrst_data", 32'(fifo_rd_data), 32'd0);
    step(1'b1, 8'h77, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("midrst_resume", 32'(fifo_rd_data), 32'h77);
    step(1'b0, 8'h00, 1'b0, 1'b0);

    check_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
